// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: CP0 register numbers, exception codes, field layouts and packing helpers
package cp0_unit_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int SR_IM_LO     = 10;
   localparam int SR_EXL       = 1;
   localparam int SR_IE        = 0;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_EXC_LO = 2;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

   typedef struct packed {
      logic       bd;
      logic [5:0] ip;
      logic [4:0] exc;
   } cause_t;

   // Architectural 32-bit view of SR; unimplemented bits read 0
   function automatic logic [31:0] sr_word(input sr_t s);
      sr_word = '0;
      sr_word[SR_IM_LO +: 6] = s.im;
      sr_word[SR_EXL]        = s.exl;
      sr_word[SR_IE]         = s.ie;
   endfunction

   // Architectural 32-bit view of Cause; unimplemented bits read 0
   function automatic logic [31:0] cause_word(input cause_t c);
      cause_word = '0;
      cause_word[CAUSE_BD]          = c.bd;
      cause_word[CAUSE_IP_LO +: 6]  = c.ip;
      cause_word[CAUSE_EXC_LO +: 5] = c.exc;
   endfunction

endpackage

// File: rtl/cp0_unit.sv
// cp0_unit: SR/Cause/EPC/PRId registers plus exception and interrupt request logic
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID_VAL     = 32'h2021_0007,
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hwint,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        cp0_we,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic [4:0]  exc_code,
   input  logic        eret,
   output logic [31:0] cp0_rdata,
   output logic [31:0] epc_out,
   output logic        exc_req,
   output logic [31:0] handler_pc
);

   sr_t         sr_q, sr_d;
   cause_t      cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic        int_pend, exc_pend, mtc0;
   logic [31:0] pc_al;
   logic        unused_ok;

   // Requests use live hwint/exc_code and are squashed while reset is held
   assign int_pend   = (|(hwint & sr_q.im)) & sr_q.ie & ~sr_q.exl & ~reset;
   assign exc_pend   = (exc_code != EXC_INT) & ~sr_q.exl & ~reset;
   assign exc_req    = int_pend | exc_pend;
   assign mtc0       = cp0_we & ~exc_req;
   assign pc_al      = {exc_pc[31:2], 2'b00};
   assign epc_out    = epc_q;
   assign handler_pc = HANDLER_ADDR;
   assign unused_ok  = ^exc_pc[1:0];

   // Register read mux; no bypass of a same-cycle write
   assign cp0_rdata = (cp0_addr == CP0_SR)    ? sr_word(sr_q)     :
                      (cp0_addr == CP0_CAUSE) ? cause_word(cause_q) :
                      (cp0_addr == CP0_EPC)   ? epc_q             :
                      (cp0_addr == CP0_PRID)  ? PRID_VAL          : '0;

   // Next state: exception entry has priority over mtc0 and eret
   always_comb begin
      sr_d     = sr_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      cause_d.ip = hwint;
      if (exc_req) begin
         sr_d.exl    = 1'b1;
         cause_d.bd  = exc_bd;
         cause_d.exc = int_pend ? EXC_INT : exc_code;
         epc_d       = exc_bd ? pc_al - 32'd4 : pc_al;
      end else begin
         if (mtc0 && cp0_addr == CP0_SR)  sr_d  = sr_t'({cp0_wdata[15:10], cp0_wdata[1:0]});
         if (mtc0 && cp0_addr == CP0_EPC) epc_d = {cp0_wdata[31:2], 2'b00};
         if (eret)                        sr_d.exl = 1'b0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q    <= '0;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         sr_q    <= sr_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed and randomized checks of cp0_unit against a word-level model
module tb_cp0_unit;

   localparam logic [31:0] PRID  = 32'h2021_0007;
   localparam logic [31:0] HADDR = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hwint;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        cp0_we;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic [4:0]  exc_code;
   logic        eret;
   logic [31:0] cp0_rdata;
   logic [31:0] epc_out;
   logic        exc_req;
   logic [31:0] handler_pc;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_sr, m_cause, m_epc;

   always #5 clk = ~clk;

   cp0_unit #(.PRID_VAL(PRID), .HANDLER_ADDR(HADDR)) dut (
      .clk(clk), .reset(reset), .hwint(hwint), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_we(cp0_we), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .exc_code(exc_code), .eret(eret), .cp0_rdata(cp0_rdata), .epc_out(epc_out),
      .exc_req(exc_req), .handler_pc(handler_pc)
   );

   function automatic logic m_int();
      return !reset && ((hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int() || (!reset && exc_code != 5'd0 && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [5:0] hw, input logic [4:0] a, input logic [31:0] wd,
                        input logic we, input logic [31:0] pc, input logic bd,
                        input logic [4:0] code, input logic er);
      hwint = hw; cp0_addr = a; cp0_wdata = wd; cp0_we = we;
      exc_pc = pc; exc_bd = bd; exc_code = code; eret = er;
      #1;
   endtask

   task automatic idle(input logic [5:0] hw);
      drive(hw, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Advance one clock edge and apply the architectural rules to the model
   task automatic tick();
      logic req, intp;
      req  = m_req();
      intp = m_int();
      @(posedge clk);
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
         if (req) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (exc_bd ? 32'h8000_0000 : 32'd0) + (intp ? 32'd0 : 32'(exc_code) * 4);
            m_epc   = (exc_pc & ~32'd3) - (exc_bd ? 32'd4 : 32'd0);
         end else begin
            if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_wdata & 32'h0000_FC03;
            if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & ~32'd3;
            if (eret) m_sr = m_sr & ~32'h2;
         end
         m_cause = (m_cause & ~32'h0000_FC00) | (32'(hwint) * 1024);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(6'd0);
      m_sr = 0; m_cause = 0; m_epc = 0;
      tick(); tick();
      @(negedge clk);
      reset = 1'b0;
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'h100, 1'b0, 5'd12, 1'b0);
      checks++;
      if (exc_req !== m_req()) begin errors++; $display("FAIL pre_reset_req got %b want %b", exc_req, m_req()); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (exc_req !== 1'b0) begin errors++; $display("FAIL async_reset_req got %b want 0", exc_req); end
      m_sr = 0; m_cause = 0; m_epc = 0;
      @(negedge clk);
      for (int a = 12; a <= 15; a++) begin
         cp0_addr = a[4:0]; #1;
         checks++;
         if (cp0_rdata !== m_rd(a[4:0])) begin errors++; $display("FAIL reset_read%0d got %h want %h", a, cp0_rdata, m_rd(a[4:0])); end
      end
      checks++;
      if (epc_out !== 32'd0) begin errors++; $display("FAIL reset_epc_out got %h want 0", epc_out); end
      checks++;
      if (handler_pc !== HADDR) begin errors++; $display("FAIL handler_pc got %h want %h", handler_pc, HADDR); end
      reset = 1'b0;
      idle(6'd0);
      tick();
   endtask

   task automatic test_timer_int();
      drive(6'd0, 5'd12, 32'h0000_0401, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(6'd1, 5'd0, 32'd0, 1'b0, 32'h3010, 1'b0, 5'd0, 1'b0);
      checks++;
      if (exc_req !== 1'b1 || m_req() !== 1'b1) begin errors++; $display("FAIL timer_req got %b want 1", exc_req); end
      tick();
      idle(6'd1);
      for (int a = 12; a <= 14; a++) begin
         cp0_addr = a[4:0]; #1;
         checks++;
         if (cp0_rdata !== m_rd(a[4:0])) begin errors++; $display("FAIL timer_read%0d got %h want %h", a, cp0_rdata, m_rd(a[4:0])); end
      end
      checks++;
      if (epc_out !== 32'h3010) begin errors++; $display("FAIL timer_epc_out got %h want 00003010", epc_out); end
      checks++;
      if (exc_req !== 1'b0) begin errors++; $display("FAIL timer_exl_block got %b want 0", exc_req); end
      tick();
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tick();
      idle(6'd0);
      cp0_addr = 5'd12; #1;
      checks++;
      if (cp0_rdata !== 32'h0000_0401) begin errors++; $display("FAIL timer_eret_sr got %h want 00000401", cp0_rdata); end
   endtask

   task automatic test_delay_slot();
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'h3024, 1'b1, 5'd12, 1'b0);
      checks++;
      if (exc_req !== m_req()) begin errors++; $display("FAIL ds_req got %b want %b", exc_req, m_req()); end
      tick();
      idle(6'd0);
      cp0_addr = 5'd14; #1;
      checks++;
      if (cp0_rdata !== 32'h3020) begin errors++; $display("FAIL ds_epc got %h want 00003020", cp0_rdata); end
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata !== 32'h8000_0030) begin errors++; $display("FAIL ds_cause got %h want 80000030", cp0_rdata); end
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tick();
   endtask

   task automatic test_simultaneous();
      drive(6'd0, 5'd12, 32'h0000_1001, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(6'd4, 5'd14, 32'h5000, 1'b1, 32'h4008, 1'b0, 5'd10, 1'b0);
      checks++;
      if (exc_req !== m_req()) begin errors++; $display("FAIL sim_req got %b want %b", exc_req, m_req()); end
      tick();
      idle(6'd4);
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata !== 32'h0000_1000) begin errors++; $display("FAIL sim_cause got %h want 00001000", cp0_rdata); end
      checks++;
      if (epc_out !== 32'h4008) begin errors++; $display("FAIL sim_epc got %h want 00004008", epc_out); end
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tick();
   endtask

   task automatic test_masking();
      drive(6'd0, 5'd12, 32'h0000_0800, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle(6'd2);
      checks++;
      if (exc_req !== 1'b0) begin errors++; $display("FAIL mask_ie0 got %b want 0", exc_req); end
      tick();
      idle(6'd2);
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata !== m_rd(5'd13) || cp0_rdata !== 32'h0000_0800) begin errors++; $display("FAIL mask_ip got %h want 00000800", cp0_rdata); end
      drive(6'd2, 5'd12, 32'h0000_0801, 1'b1, 32'h7000, 1'b0, 5'd0, 1'b0);
      checks++;
      if (exc_req !== 1'b0) begin errors++; $display("FAIL mask_mtc0_cycle got %b want 0", exc_req); end
      tick();
      drive(6'd2, 5'd0, 32'd0, 1'b0, 32'h7004, 1'b0, 5'd0, 1'b0);
      checks++;
      if (exc_req !== 1'b1) begin errors++; $display("FAIL mask_ie1 got %b want 1", exc_req); end
      tick();
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tick();
   endtask

   task automatic test_eret_vs_req();
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'h6000, 1'b0, 5'd4, 1'b1);
      checks++;
      if (exc_req !== 1'b1) begin errors++; $display("FAIL ev_req got %b want 1", exc_req); end
      tick();
      idle(6'd0);
      cp0_addr = 5'd12; #1;
      checks++;
      if (cp0_rdata[1] !== 1'b1) begin errors++; $display("FAIL ev_exl got %b want 1", cp0_rdata[1]); end
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata !== 32'h0000_0010) begin errors++; $display("FAIL ev_cause got %h want 00000010", cp0_rdata); end
      drive(6'd0, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(6'd0, 5'd15, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle(6'd0);
      for (int a = 13; a <= 15; a += 2) begin
         cp0_addr = a[4:0]; #1;
         checks++;
         if (cp0_rdata !== m_rd(a[4:0])) begin errors++; $display("FAIL ev_ro%0d got %h want %h", a, cp0_rdata, m_rd(a[4:0])); end
      end
      drive(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      logic [4:0] codes [7];
      codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
      for (int i = 0; i < 400; i++) begin
         drive(6'($urandom_range(0, 7)), 5'($urandom_range(10, 17)), $urandom,
               ($urandom_range(0, 2) == 0), $urandom, 1'($urandom),
               codes[$urandom_range(0, 6)], ($urandom_range(0, 5) == 0));
         checks++;
         if (exc_req !== m_req()) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", i, exc_req, m_req()); end
         checks++;
         if (cp0_rdata !== m_rd(cp0_addr)) begin errors++; $display("FAIL rnd_rd[%0d] a=%0d got %h want %h", i, cp0_addr, cp0_rdata, m_rd(cp0_addr)); end
         checks++;
         if (epc_out !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d] got %h want %h", i, epc_out, m_epc); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_timer_int();
      test_delay_slot();
      test_simultaneous();
      test_masking();
      test_eret_vs_req();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block that receives the 6-bit interrupt vector {3'b0, interrupt, T1 IRQ, T0 IRQ} built at the top level.
- Also receives synchronous exception codes from the pipeline.
- Holds SR, Cause, EPC and PRId, and decides when to take an exception or interrupt.
- Supplies the pipeline with the flush/redirect request, the handler address and EPC for eret.

Parameters:
- PRID_VAL, 32'h2021_0007, read-only value returned for register 15.
- HANDLER_ADDR, 32'h0000_4180, redirect target when exc_req is asserted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hwint  in  6  raw interrupt lines; bit0 = T0, bit1 = T1, bit2 = external interrupt, bits 5:3 tied 0.
- cp0_addr  in  5  register number for mfc0/mtc0.
- cp0_wdata  in  32  mtc0 write data.
- cp0_we  in  1  mtc0 write enable.
- exc_pc  in  32  PC of the instruction currently at the macroscopic (M) point.
- exc_bd  in  1  that instruction is in a branch delay slot.
- exc_code  in  5  pipeline-detected exception code; 0 means none.
- eret  in  1  eret committing this cycle.
- cp0_rdata  out  32  combinational read of the addressed register.
- epc_out  out  32  current EPC, used for the eret redirect.
- exc_req  out  1  take exception/interrupt this cycle; flushes pipeline.
- handler_pc  out  32  constant HANDLER_ADDR.

Behaviour:
- Register fields:
  - SR(12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0.
  - Cause(13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; all other bits read 0.
  - EPC(14): 32-bit, bits 1:0 always 0.
  - PRId(15): PRID_VAL.
  - Any other address reads 0.
- Reset (asynchronous, immediate): SR = 0, Cause = 0, EPC = 0. Outputs follow: exc_req = 0, cp0_rdata = value of the addressed register, epc_out = 0.
- IP tracking: Cause.IP <= hwint every cycle, independent of EXL.
- Interrupt pending: int_pend = |(hwint & SR.IM) & SR.IE & ~SR.EXL. Uses live hwint, so there is no extra cycle of latency.
- Exception pending: exc_pend = (exc_code != 0) & ~SR.EXL.
- Request: exc_req = int_pend | exc_pend, purely combinational in the same cycle.
- Priority: an interrupt wins over a simultaneous exception; ExcCode is then 0 (Int).
- On exc_req (rising edge):
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_pend ? 0 : exc_code.
  - Cause.BD <= exc_bd.
  - EPC <= exc_bd ? {exc_pc[31:2],2'b0} - 4 : {exc_pc[31:2],2'b0}.
- mtc0 (cp0_we & ~exc_req):
  - Addr 12 writes IM, EXL and IE only.
  - Addr 14 writes EPC with bits 1:0 cleared.
  - Addr 13 and 15 are read-only; writes are ignored.
  - mtc0 in the same cycle as exc_req is dropped; exception state wins.
- eret (eret & ~exc_req): SR.EXL <= 0 next edge. If exc_req is also asserted, exception handling wins and EXL stays 1.
- While EXL = 1: no new requests are raised; hwint changes are still visible in Cause.IP.
- Read/write bypass: reads show the pre-edge register value (no write-to-read bypass). epc_out is the registered EPC.
- A reset pulse in mid-handler clears EXL and drops any pending request immediately.

Decomposition:
- Shared constants package (const.v additions):
  - CP0 register numbers 12/13/14/15.
  - ExcCode values: EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - Field bit positions for IM, EXL, IE, BD, IP and ExcCode.
  - HANDLER_ADDR default.
- Single module, no sub-module. The request/priority logic is a small combinational section inside it.

Test Plan:
- Reset then read:
  - Assert reset async mid-cycle -> exc_req = 0 immediately.
  - Read addr 15 -> 32'h2021_0007; addr 12/13/14 -> 0.
- Timer interrupt:
  - mtc0 SR = 32'h0000_0401 (IM0 = 1, IE = 1), then hwint = 6'b000001 with exc_pc = 32'h3010 -> exc_req = 1 same cycle.
  - Next cycle: EPC = 32'h3010, Cause = 32'h0000_0400, SR reads 32'h0000_0403.
  - Further hwint produces no exc_req until eret, after which SR.EXL = 0.
- Exception in delay slot:
  - exc_code = 12 (Ov), exc_bd = 1, exc_pc = 32'h3024 -> EPC = 32'h3020.
  - Cause = 32'h8000_0030 with hwint = 0.
- Simultaneous events:
  - exc_code = 10, hwint = 6'b000100, IM2 = 1, IE = 1 -> ExcCode = 0, not 10.
  - mtc0 EPC = 32'h5000 in the same cycle is dropped; EPC = exc_pc.
- Masking:
  - IE = 0 with hwint = 6'b000010 and IM1 = 1 -> exc_req = 0; Cause.IP = 6'b000010.
  - Set IE = 1 -> exc_req = 1 the cycle after the mtc0 edge.
- eret vs request:
  - eret = 1 together with exc_code = 4 while EXL = 0 -> EXL ends at 1, ExcCode = 4.
  - mtc0 to addr 13 leaves Cause unchanged.
